// File: rtl/immediate_generator_pkg.sv
// Shared opcode constants and immediate-format enum for the RV64I immediate generator.
package immediate_generator_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

endpackage

// File: rtl/imm_format_decode.sv
// Maps a 7-bit opcode to its immediate format; unknown opcodes give FMT_NONE and valid=0.
module imm_format_decode
  import immediate_generator_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_fmt_e   fmt,
  output logic       valid
);

  always_comb begin
    fmt = FMT_NONE;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: fmt = FMT_I;
      OP_STORE:                           fmt = FMT_S;
      OP_BRANCH:                          fmt = FMT_B;
      OP_LUI, OP_AUIPC:                   fmt = FMT_U;
      OP_JAL:                             fmt = FMT_J;
      default:                            fmt = FMT_NONE;
    endcase
  end

  assign valid = (fmt != FMT_NONE);

endmodule

// File: rtl/immediate_generator.sv
// RV64I immediate generator: field assembly and sign extension, plus a sticky illegal-opcode flag.
// Define IMM_REG_EN to register imm/imm_valid (1-cycle latency).
module immediate_generator
  import immediate_generator_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output logic            imm_valid,
  output logic            illegal_seen
);

  imm_fmt_e        fmt;
  logic            valid_comb;
  logic [XLEN-1:0] imm_comb;
  logic            sign;
  logic            illegal_q;

  assign sign = instruction[31];

  imm_format_decode u_decode (
    .opcode (instruction[6:0]),
    .fmt    (fmt),
    .valid  (valid_comb)
  );

  always_comb begin
    imm_comb = '0;
    case (fmt)
      FMT_I: imm_comb = {{(XLEN-12){sign}}, instruction[31:20]};
      FMT_S: imm_comb = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm_comb = {{(XLEN-13){sign}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm_comb = {{(XLEN-32){sign}}, instruction[31:12], 12'b0};
      FMT_J: imm_comb = {{(XLEN-21){sign}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
      default: imm_comb = '0;
    endcase
  end

`ifdef IMM_REG_EN
  logic [XLEN-1:0] imm_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_comb;
      valid_q <= valid_comb;
    end
  end

  assign imm       = imm_q;
  assign imm_valid = valid_q;
`else
  assign imm       = imm_comb;
  assign imm_valid = valid_comb;
`endif

  // Sticky: reset has priority over a concurrent invalid opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (!imm_valid) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_seen = illegal_q;

endmodule

// File: tb/tb_immediate_generator.sv
// Scoreboard bench for immediate_generator (default combinational build).
module tb_immediate_generator;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            rst;
  logic [31:0]     instruction;
  logic [XLEN-1:0] imm;
  logic            imm_valid;
  logic            illegal_seen;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_pushed = 0;
  int n_popped = 0;

  logic cur_valid_exp = 1'b1;
  logic ill_exp = 1'b0;
  logic started = 1'b0;

  immediate_generator #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .imm          (imm),
    .imm_valid    (imm_valid),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: signed slices widened by assignment.
  function automatic void ref_imm(input logic [31:0] in, output logic [63:0] val,
                                  output logic ok);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    logic signed [63:0] w;
    ok = 1'b1;
    w  = 0;
    case (in[6:0])
      7'h13, 7'h03, 7'h67, 7'h1B: begin i12 = in[31:20]; w = i12; end
      7'h23: begin i12 = {in[31:25], in[11:7]}; w = i12; end
      7'h63: begin b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0}; w = b13; end
      7'h37, 7'h17: begin u32 = {in[31:12], 12'h000}; w = u32; end
      7'h6F: begin j21 = {in[31], in[19:12], in[20], in[30:21], 1'b0}; w = j21; end
      default: begin ok = 1'b0; w = 0; end
    endcase
    val = w;
  endfunction

  task automatic drive(input logic [31:0] in, input logic r, input logic [63:0] e_imm,
                       input logic e_valid);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    instruction   = in;
    cur_valid_exp = e_valid;
    e.instr = in;
    e.imm   = e_imm;
    e.valid = e_valid;
    exp_q.push_back(e);
    n_pushed++;
    started = 1'b1;
  endtask

  task automatic drive_ref(input logic [31:0] in, input logic r);
    logic [63:0] v;
    logic ok;
    ref_imm(in, v, ok);
    drive(in, r, v, ok);
  endtask

  always @(posedge clk) begin
    if (rst) ill_exp = 1'b0;
    else if (!cur_valid_exp) ill_exp = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) check("illegal_seen", {63'd0, illegal_seen}, {63'd0, ill_exp});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_popped++;
      check($sformatf("imm[%h]", e.instr), imm, e.imm);
      check($sformatf("imm_valid[%h]", e.instr), {63'd0, imm_valid}, {63'd0, e.valid});
    end
  end

  initial begin
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    rst = 1'b1;
    instruction = 32'h00A00093;

    drive(32'h00A00093, 1'b1, 64'd10, 1'b1);
    drive(32'h00A00093, 1'b1, 64'd10, 1'b1);
    drive(32'h00A00093, 1'b0, 64'd10, 1'b1);
    drive(32'hFFB00093, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    drive(32'h00303823, 1'b0, 64'd16, 1'b1);
    drive(32'h00208463, 1'b0, 64'd8, 1'b1);
    drive(32'h800000B7, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b1);
    drive(32'hFFDFF06F, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    drive(32'h00000033, 1'b0, 64'd0, 1'b0);
    drive(32'h00A00093, 1'b0, 64'd10, 1'b1);
    drive(32'h00A00093, 1'b1, 64'd10, 1'b1);
    drive(32'hFFFFFFFF, 1'b0, 64'd0, 1'b0);
    drive(32'h00A00093, 1'b0, 64'd10, 1'b1);
    drive(32'h00A00093, 1'b1, 64'd10, 1'b1);
    // Reset concurrent with an invalid opcode must leave the flag clear.
    drive(32'hFFFFFFFF, 1'b1, 64'd0, 1'b0);
    drive(32'h00A00093, 1'b0, 64'd10, 1'b1);
    drive(32'h00A00093, 1'b0, 64'd10, 1'b1);

    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      if (i % 8 != 7) r[6:0] = ops[$urandom_range(0, 9)];
      drive_ref(r, (i % 20 == 19) ? 1'b1 : 1'b0);
    end

    @(posedge clk);
    #1;
    cur_valid_exp = 1'b1;
    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("pop_count", 64'(n_popped), 64'(n_pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
